ps2_key_ctrl: RTL

//  Sequences the PS/2 keyboard receive path for Top. Synchronises PS2_CLK/PS2_DATA and frames
//  11-bit PS/2 packets. Decodes the E0/F0 prefixes into make/break key events.

---
 rtl/ps2_key_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receive path: input synchronisers, 11-bit frame receiver with
// timeout, E0/F0 prefix decoder, show-ahead event FIFO and held-key bitmap.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] key_state,
    output logic       frame_err,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    // Scan codes of the tracked keys, bit i of key_state <-> byte i here
    localparam logic [63:0] KEY_CODES = {8'h2D, 8'h76, 8'h5A, 8'h29,
                                         8'h23, 8'h1B, 8'h1C, 8'h1D};

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic          clk_meta, clk_sync, clk_prev;
    logic          data_meta, data_sync;
    logic          fall;
    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_reg, stop_reg;
    logic [TW-1:0] tmo_cnt;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          ext_flag, brk_flag;
    logic          emit;
    logic [7:0]    key_hit;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [9:0]    head_word, last_word, new_word;
    logic          full, push, pop;

    // Two-stage synchronisers plus one delayed copy of the clock for edge detect
    always_ff @(posedge clk) begin
        if (!rstn) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= PS2_CLK;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= PS2_DATA;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    // Frame receiver: start/data/parity/stop collection, timeout and frame check
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            stop_reg   <= 1'b0;
            tmo_cnt    <= '0;
            frame_err  <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
        end else begin
            frame_err  <= 1'b0;
            byte_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall && !data_sync) begin
                        state   <= RECV;
                        bit_cnt <= 4'd1;
                        tmo_cnt <= '0;
                    end
                end
                RECV: begin
                    if (fall) begin
                        tmo_cnt <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt <= 4'd8) begin
                            shift_reg <= {data_sync, shift_reg[7:1]};
                        end else if (bit_cnt == 4'd9) begin
                            parity_reg <= data_sync;
                        end else begin
                            stop_reg <= data_sync;
                            state    <= CHECK;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                CHECK: begin
                    if ((^{shift_reg, parity_reg}) && stop_reg) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift_reg;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign emit = byte_valid && (byte_data != 8'hE0) && (byte_data != 8'hF0);

    // Prefix flags: set by E0/F0, consumed by the next emitted code or a bad frame
    always_ff @(posedge clk) begin
        if (!rstn || frame_err) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_valid) begin
            if (byte_data == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (byte_data == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_key
        assign key_hit[gi] = emit && !ext_flag && (byte_data == KEY_CODES[gi*8 +: 8]);
    end

    // Held-key bitmap; updated whether or not the event fits in the FIFO
    always_ff @(posedge clk) begin
        if (!rstn) begin
            key_state <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (key_hit[i]) key_state[i] <= ~brk_flag;
            end
        end
    end

    assign evt_valid = (count != '0);
    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop       = evt_valid & evt_ready;
    assign push      = emit & (~full | pop);
    assign new_word  = {ext_flag, brk_flag, byte_data};
    assign head_word = mem[rd_ptr];
    assign {evt_ext, evt_break, evt_code} = evt_valid ? head_word : last_word;

    // Event storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_word;
    end

    // FIFO pointers, occupancy, overflow pulse and the held copy of the last head
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            last_word <= '0;
        end else begin
            overflow <= emit & ~push;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (evt_valid) last_word <= head_word;
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
